// File: rtl/vlc_avalon_pkg.sv
// Shared types and helpers for the VLC/HDMI Avalon masters.
package vlc_avalon_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Ceiling log2, used to turn the byte stride into a shift amount.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/write_master_pipeline_hdmi.sv
// Avalon-MM write master: drains a show-ahead FIFO into a contiguous region,
// one single-beat write per word, back-to-back when the FIFO keeps up.
// Optional macro WRITE_MASTER_TIMEOUT_EN adds a wait-request watchdog
// (TIMEOUT_CYC parameter, sticky oTimeout output).
module write_master_pipeline_hdmi
  import vlc_avalon_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDRESS_INC = 4
`ifdef WRITE_MASTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic                iClk,
  input  logic                iReset_n,
  input  logic                iStart,
  input  logic [ADDR_W-1:0]   iStart_write_address,
  input  logic [31:0]         iLength,
  input  logic                iWait_request,
  output logic                oWrite,
  output logic [ADDR_W-1:0]   oWrite_address,
  output logic [DATA_W-1:0]   oWrite_data,
  output logic [DATA_W/8-1:0] oByteenable,
  input  logic                iFF_empty,
  input  logic [DATA_W-1:0]   iFF_data,
  output logic                oFF_rd,
  output logic                oBusy,
`ifdef WRITE_MASTER_TIMEOUT_EN
  output logic                oTimeout,
`endif
  output logic                oDone
);

  localparam int SHIFT = clog2(ADDRESS_INC);

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [31:0]         rem_q, rem_d;
  logic [31:0]         words;
  logic                ff_rd;

`ifdef WRITE_MASTER_TIMEOUT_EN
  logic [15:0]         tcnt_q, tcnt_d;
  logic                to_q, to_d;
  assign oTimeout = to_q;
`endif

  // Low length bits below the word size are dropped.
  assign words = iLength >> SHIFT;

  assign oWrite         = write_q;
  assign oWrite_address = addr_q;
  assign oWrite_data    = data_q;
  assign oByteenable    = {(DATA_W/8){write_q}};
  assign oBusy          = (state_q != IDLE);
  assign oDone          = (state_q == DONE);
  assign oFF_rd         = ff_rd;

  // State and datapath registers; reset aborts any transfer immediately.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rem_q   <= '0;
`ifdef WRITE_MASTER_TIMEOUT_EN
      tcnt_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
`ifdef WRITE_MASTER_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      to_q    <= to_d;
`endif
    end
  end

  // Next-state, FIFO pop and datapath updates.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rem_d   = rem_q;
    ff_rd   = 1'b0;
`ifdef WRITE_MASTER_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    to_d    = to_q;
`endif
    case (state_q)
      IDLE: begin
        if (iStart) begin
          addr_d  = iStart_write_address;
          rem_d   = words;
          state_d = (words == '0) ? DONE : FETCH;
`ifdef WRITE_MASTER_TIMEOUT_EN
          to_d    = 1'b0;
          tcnt_d  = '0;
`endif
        end
      end
      FETCH: begin
        if (!iFF_empty) begin
          ff_rd   = 1'b1;
          data_d  = iFF_data;
          write_d = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (!iWait_request) begin
          addr_d = addr_q + ADDR_W'(ADDRESS_INC);
          rem_d  = rem_q - 32'd1;
`ifdef WRITE_MASTER_TIMEOUT_EN
          tcnt_d = '0;
`endif
          if (rem_q == 32'd1) begin
            write_d = 1'b0;
            state_d = DONE;
          end else if (!iFF_empty) begin
            // Pop the next head word in the accept cycle for back-to-back beats.
            ff_rd  = 1'b1;
            data_d = iFF_data;
          end else begin
            write_d = 1'b0;
            state_d = FETCH;
          end
        end
`ifdef WRITE_MASTER_TIMEOUT_EN
        else if (tcnt_q == 16'(TIMEOUT_CYC - 1)) begin
          write_d = 1'b0;
          to_d    = 1'b1;
          tcnt_d  = '0;
          state_d = DONE;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
`endif
      end
      DONE: begin
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
